// File: rtl/mult_hilo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_hilo_ctrl_if
// Description : Bus bundle between the control unit / multiplier array and the
//               HI/LO multiply sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_hilo_ctrl_if;
    logic        start;
    logic        signed_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic [31:0] ms_hi;
    logic [31:0] ms_lo;
    logic [31:0] mu_hi;
    logic [31:0] mu_lo;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    // The master side is the control unit together with the combinational multipliers.
    modport master (
        output start, signed_op, op1, op2,
        output ms_hi, ms_lo, mu_hi, mu_lo,
        output wr_hi, wr_lo, wdata,
        input  mult_a, mult_b, hi, lo, busy, done
    );

    modport slave (
        input  start, signed_op, op1, op2,
        input  ms_hi, ms_lo, mu_hi, mu_lo,
        input  wr_hi, wr_lo, wdata,
        output mult_a, mult_b, hi, lo, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/mult_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_hilo_ctrl
// Description : Multi-cycle multiply sequencer with architectural HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_hilo_ctrl #(
    parameter int MUL_LATENCY = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mult_hilo_ctrl_if.slave  bus
);

    localparam logic [3:0] c_latency = 4'(MUL_LATENCY);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_count;
    logic [3:0]  w_count_nxt;
    logic        r_sign;
    logic        w_sign_nxt;
    logic [31:0] r_mult_a;
    logic [31:0] w_mult_a_nxt;
    logic [31:0] r_mult_b;
    logic [31:0] w_mult_b_nxt;
    logic [31:0] r_hi;
    logic [31:0] w_hi_nxt;
    logic [31:0] r_lo;
    logic [31:0] w_lo_nxt;
    logic        r_done;
    logic        w_capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A same-edge write and START both apply; the later capture overwrites HI/LO.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_sign_nxt   = r_sign;
        w_mult_a_nxt = r_mult_a;
        w_mult_b_nxt = r_mult_b;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_capture    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.wr_hi) begin
                    w_hi_nxt = bus.wdata;
                end
                if (bus.wr_lo) begin
                    w_lo_nxt = bus.wdata;
                end
                if (bus.start) begin
                    w_mult_a_nxt = bus.op1;
                    w_mult_b_nxt = bus.op2;
                    w_sign_nxt   = bus.signed_op;
                    w_count_nxt  = c_latency;
                    w_state_nxt  = ST_WAIT;
                end
            end

            ST_WAIT: begin
                w_count_nxt = r_count - 4'd1;
                if (r_count == 4'd1) begin
                    w_capture   = 1'b1;
                    w_hi_nxt    = r_sign ? bus.ms_hi : bus.mu_hi;
                    w_lo_nxt    = r_sign ? bus.ms_lo : bus.mu_lo;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= 4'd0;
            r_sign   <= 1'b0;
            r_mult_a <= 32'd0;
            r_mult_b <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_sign   <= w_sign_nxt;
            r_mult_a <= w_mult_a_nxt;
            r_mult_b <= w_mult_b_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_done   <= w_capture;
        end
    end

    assign bus.mult_a = r_mult_a;
    assign bus.mult_b = r_mult_b;
    assign bus.hi     = r_hi;
    assign bus.lo     = r_lo;
    assign bus.busy   = (r_state == ST_WAIT);
    assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mult_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_hilo_ctrl
// Description : Self-checking bench for mult_hilo_ctrl with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_hilo_ctrl;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst;
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic [31:0] exp_a;
    logic [31:0] exp_b;

    mult_hilo_ctrl_if bus ();

    mult_hilo_ctrl #(.MUL_LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        if (s) begin
            sa = longint'(int'(a));
            sb = longint'(int'(b));
            return 64'(sa * sb);
        end
        ua = 64'(a);
        ub = 64'(b);
        return ua * ub;
    endfunction

    // Stand-in for the combinational signed and unsigned multiplier arrays.
    assign {bus.ms_hi, bus.ms_lo} = ref_prod(bus.mult_a, bus.mult_b, 1'b1);
    assign {bus.mu_hi, bus.mu_lo} = ref_prod(bus.mult_a, bus.mult_b, 1'b0);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic busy, input logic done);
        chk({tag, ".busy"},   64'(bus.busy),   64'(busy));
        chk({tag, ".done"},   64'(bus.done),   64'(done));
        chk({tag, ".hi"},     64'(bus.hi),     64'(exp_hi));
        chk({tag, ".lo"},     64'(bus.lo),     64'(exp_lo));
        chk({tag, ".mult_a"}, 64'(bus.mult_a), 64'(exp_a));
        chk({tag, ".mult_b"}, 64'(bus.mult_b), 64'(exp_b));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
    endtask

    task automatic do_write(input logic wh, input logic wl, input logic [31:0] d);
        bus.wr_hi = wh;
        bus.wr_lo = wl;
        bus.wdata = d;
        tick();
        idle_inputs();
        if (wh) exp_hi = d;
        if (wl) exp_lo = d;
        check_all("write", 1'b0, 1'b0);
    endtask

    // inj > 0 pulses junk START and writes on that WAIT edge; they must be ignored.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic wh, input logic wl, input logic [31:0] wd,
                           input int inj);
        logic [63:0] p;
        p             = ref_prod(a, b, s);
        bus.start     = 1'b1;
        bus.op1       = a;
        bus.op2       = b;
        bus.signed_op = s;
        bus.wr_hi     = wh;
        bus.wr_lo     = wl;
        bus.wdata     = wd;
        tick();
        idle_inputs();
        if (wh) exp_hi = wd;
        if (wl) exp_lo = wd;
        exp_a = a;
        exp_b = b;
        check_all("mul.accept", 1'b1, 1'b0);
        for (int k = 1; k < L; k++) begin
            if (k == inj) begin
                bus.start     = 1'b1;
                bus.op1       = 32'd2;
                bus.op2       = 32'd2;
                bus.signed_op = ~s;
                bus.wr_hi     = 1'b1;
                bus.wr_lo     = 1'b1;
                bus.wdata     = 32'hDEADBEEF;
            end
            tick();
            idle_inputs();
            check_all("mul.wait", 1'b1, 1'b0);
        end
        tick();
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        check_all("mul.capture", 1'b0, 1'b1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.wr_hi     = 1'b1;
        bus.wr_lo     = 1'b0;
        bus.wdata     = 32'hFFFFFFFF;
        bus.signed_op = 1'b1;
        bus.op1       = 32'd5;
        bus.op2       = 32'd5;
        exp_hi        = 32'd0;
        exp_lo        = 32'd0;
        exp_a         = 32'd0;
        exp_b         = 32'd0;

        // Reset dominates START and WR_HI.
        tick();
        check_all("reset1", 1'b0, 1'b0);
        tick();
        check_all("reset2", 1'b0, 1'b0);
        rst = 1'b0;
        idle_inputs();

        // First START right after reset: -3 * 5 signed.
        run_mul(32'hFFFFFFFD, 32'd5, 1'b1, 1'b0, 1'b0, 32'd0, 0);
        chk("spec.signed.hi", 64'(bus.hi), 64'hFFFFFFFF);
        chk("spec.signed.lo", 64'(bus.lo), 64'hFFFFFFF1);

        // Issued during the DONE cycle each time (back-to-back).
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'd0, 0);
        chk("spec.unsigned.hi", 64'(bus.hi), 64'hFFFFFFFE);
        chk("spec.unsigned.lo", 64'(bus.lo), 64'h00000001);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'd0, 0);
        chk("spec.minus1sq.hi", 64'(bus.hi), 64'h0);
        chk("spec.minus1sq.lo", 64'(bus.lo), 64'h1);
        run_mul(32'h00010000, 32'h00010000, 1'b0, 1'b0, 1'b0, 32'd0, 0);
        chk("spec.b2b.hi", 64'(bus.hi), 64'h1);
        chk("spec.b2b.lo", 64'(bus.lo), 64'h0);

        tick();
        check_all("idle.hold1", 1'b0, 1'b0);
        tick();
        check_all("idle.hold2", 1'b0, 1'b0);

        // Requests arriving mid-WAIT are dropped.
        do_write(1'b1, 1'b0, 32'h11111111);
        run_mul(32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 32'd0, 2);
        chk("spec.ignore.hi", 64'(bus.hi), 64'h0);
        chk("spec.ignore.lo", 64'(bus.lo), 64'd42);
        tick();
        check_all("ignore.no_second", 1'b0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_write(1'($urandom), 1'($urandom), $urandom);
            end else begin
                run_mul($urandom, $urandom, 1'($urandom),
                        ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom,
                        int'($urandom_range(0, L - 1)));
            end
            if ($urandom_range(0, 1) == 1) begin
                tick();
                check_all("rand.idle", 1'b0, 1'b0);
            end
        end

        // Reset on the second WAIT edge aborts the multiply.
        bus.start     = 1'b1;
        bus.op1       = 32'd3;
        bus.op2       = 32'd3;
        bus.signed_op = 1'b0;
        tick();
        idle_inputs();
        exp_a = 32'd3;
        exp_b = 32'd3;
        check_all("abort.accept", 1'b1, 1'b0);
        tick();
        check_all("abort.wait", 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        exp_a  = 32'd0;
        exp_b  = 32'd0;
        check_all("abort.reset", 1'b0, 1'b0);
        for (int k = 0; k < L; k++) begin
            tick();
            check_all("abort.after", 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
